vector_writeback: RTL and testbench

VECTOR_WRITEBACK -- requirements
Module: vector_writeback

---
 rtl/vector_writeback.sv | 112 +++++++++++
 tb/tb_vector_writeback.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_writeback.sv
// Writeback queue between the vector execution stage and the register file.
// In-order FIFO with a registered write port and a pending-register scoreboard mask.
module vector_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_index,
    input  logic [31:0] in_data,
    input  logic        rf_stall,
    output logic        update_enable,
    output logic [3:0]  indexVd,
    output logic [31:0] update_register,
    output logic [15:0] pending_mask,
    output logic [15:0] writes_issued
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [35:0]   mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          update_enable_q, update_enable_d;
    logic [3:0]    index_vd_q, index_vd_d;
    logic [31:0]   update_register_q, update_register_d;
    logic [15:0]   writes_issued_q, writes_issued_d;

    logic          push;
    logic          pop;
    logic [35:0]   head;
    logic [PW-1:0] offs;
    logic [15:0]   pending_c;

    assign in_ready        = (count_q < CW'(DEPTH));
    assign update_enable   = update_enable_q;
    assign indexVd         = index_vd_q;
    assign update_register = update_register_q;
    assign writes_issued   = writes_issued_q;
    assign pending_mask    = pending_c;

    always_comb begin
        push              = in_valid && in_ready;
        pop               = (count_q != '0) && !rf_stall;
        head              = mem[rd_ptr_q];
        wr_ptr_d          = wr_ptr_q + PW'(push);
        rd_ptr_d          = rd_ptr_q + PW'(pop);
        count_d           = count_q;
        update_enable_d   = pop;
        index_vd_d        = index_vd_q;
        update_register_d = update_register_q;
        writes_issued_d   = writes_issued_q + 16'(pop);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop) begin
            index_vd_d        = head[35:32];
            update_register_d = head[31:0];
        end
    end

    // Slot i holds a live entry when its distance from the read pointer is below the count.
    always_comb begin
        pending_c = '0;
        offs      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr_q;
            if (CW'(offs) < count_q) begin
                pending_c[mem[i][35:32]] = 1'b1;
            end
        end
        if (update_enable_q) begin
            pending_c[index_vd_q] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            update_enable_q   <= 1'b0;
            index_vd_q        <= '0;
            update_register_q <= '0;
            writes_issued_q   <= '0;
        end else begin
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            update_enable_q   <= update_enable_d;
            index_vd_q        <= index_vd_d;
            update_register_q <= update_register_d;
            writes_issued_q   <= writes_issued_d;
        end
    end

    // Storage is intentionally not reset; only slots covered by the count are ever observed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_index, in_data};
        end
    end

endmodule

// File: tb/tb_vector_writeback.sv
// Directed self-checking bench for vector_writeback (DEPTH = 4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_vector_writeback;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_index;
    logic [31:0] in_data;
    logic        rf_stall;
    logic        update_enable;
    logic [3:0]  indexVd;
    logic [31:0] update_register;
    logic [15:0] pending_mask;
    logic [15:0] writes_issued;

    int tests_run;
    int tests_failed;

    vector_writeback #(.DEPTH(4)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_index        (in_index),
        .in_data         (in_data),
        .rf_stall        (rf_stall),
        .update_enable   (update_enable),
        .indexVd         (indexVd),
        .update_register (update_register),
        .pending_mask    (pending_mask),
        .writes_issued   (writes_issued)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic any_pulse;
        tests_run    = 0;
        tests_failed = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_index = '0;
        in_data  = '0;
        rf_stall = 1'b0;

        // Reset state
        step();
        step();
        reset_n = 1'b1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_pending", 32'(pending_mask), 32'h0);
        check_eq("rst_ue", 32'(update_enable), 32'd0);
        check_eq("rst_writes", 32'(writes_issued), 32'd0);
        check_eq("rst_idx", 32'(indexVd), 32'd0);
        check_eq("rst_data", update_register, 32'h0);

        // Single write
        in_valid = 1'b1;
        in_index = 4'd3;
        in_data  = 32'h01020304;
        step();
        in_valid = 1'b0;
        check_eq("single_ue_early", 32'(update_enable), 32'd0);
        check_eq("single_pend_q", 32'(pending_mask), 32'h0008);
        step();
        check_eq("single_ue", 32'(update_enable), 32'd1);
        check_eq("single_idx", 32'(indexVd), 32'd3);
        check_eq("single_data", update_register, 32'h01020304);
        check_eq("single_writes", 32'(writes_issued), 32'd1);
        check_eq("single_pend_port", 32'(pending_mask), 32'h0008);
        step();
        check_eq("single_ue_off", 32'(update_enable), 32'd0);
        check_eq("single_pend_off", 32'(pending_mask), 32'h0);
        check_eq("single_data_hold", update_register, 32'h01020304);

        // Fill under stall
        rf_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_eq("fill_ready_pre", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_index = 4'(k);
            in_data  = 32'h10000000 + k;
            step();
        end
        check_eq("fill_ready_full", 32'(in_ready), 32'd0);
        check_eq("fill_pend", 32'(pending_mask), 32'h001E);
        in_index = 4'd9;
        in_data  = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        check_eq("fill_5th_ready", 32'(in_ready), 32'd0);
        check_eq("fill_5th_pend", 32'(pending_mask), 32'h001E);
        check_eq("fill_stall_ue", 32'(update_enable), 32'd0);
        rf_stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_eq("drain_ue", 32'(update_enable), 32'd1);
            check_eq("drain_idx", 32'(indexVd), 32'(k));
            check_eq("drain_data", update_register, 32'h10000000 + k);
        end
        step();
        check_eq("drain_ue_off", 32'(update_enable), 32'd0);
        check_eq("drain_pend", 32'(pending_mask), 32'h0);
        check_eq("drain_writes", 32'(writes_issued), 32'd5);
        check_eq("drain_ready", 32'(in_ready), 32'd1);

        // Streaming: one push per cycle, one pop per cycle
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_index = 4'(k);
            in_data  = 32'hC0DE0000 + k;
            step();
            check_eq("stream_ready", 32'(in_ready), 32'd1);
            if (k == 0) begin
                check_eq("stream_pend0", 32'(pending_mask), 32'h0001);
            end else begin
                check_eq("stream_ue", 32'(update_enable), 32'd1);
                check_eq("stream_idx", 32'(indexVd), 32'(k - 1));
                check_eq("stream_data", update_register, 32'hC0DE0000 + k - 1);
                check_eq("stream_pend", 32'(pending_mask), (32'd1 << k) | (32'd1 << (k - 1)));
            end
        end
        in_valid = 1'b0;
        step();
        check_eq("stream_last_ue", 32'(update_enable), 32'd1);
        check_eq("stream_last_data", update_register, 32'hC0DE0009);
        step();
        check_eq("stream_end_ue", 32'(update_enable), 32'd0);
        check_eq("stream_writes", 32'(writes_issued), 32'd15);

        // Same destination index twice
        in_valid = 1'b1;
        in_index = 4'd5;
        in_data  = 32'hAAAAAAAA;
        step();
        in_data  = 32'h55555555;
        step();
        in_valid = 1'b0;
        check_eq("same_ue1", 32'(update_enable), 32'd1);
        check_eq("same_data1", update_register, 32'hAAAAAAAA);
        check_eq("same_pend1", 32'(pending_mask), 32'h0020);
        step();
        check_eq("same_ue2", 32'(update_enable), 32'd1);
        check_eq("same_data2", update_register, 32'h55555555);
        check_eq("same_pend2", 32'(pending_mask), 32'h0020);
        step();
        check_eq("same_ue_off", 32'(update_enable), 32'd0);
        check_eq("same_pend_off", 32'(pending_mask), 32'h0);

        // Reset with three entries queued
        rf_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_index = 4'(k + 7);
            in_data  = 32'h77000000 + k;
            step();
        end
        in_valid = 1'b0;
        check_eq("mid_pend_pre", 32'(pending_mask), 32'h0380);
        reset_n  = 1'b0;
        step();
        reset_n  = 1'b1;
        rf_stall = 1'b0;
        check_eq("mid_ready", 32'(in_ready), 32'd1);
        check_eq("mid_writes", 32'(writes_issued), 32'd0);
        check_eq("mid_pend", 32'(pending_mask), 32'h0);
        any_pulse = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (update_enable) any_pulse = 1'b1;
        end
        check_eq("mid_no_pulse", 32'(any_pulse), 32'd0);
        check_eq("mid_writes_after", 32'(writes_issued), 32'd0);

        // 65536 writes wrap the issue counter
        in_valid = 1'b1;
        for (int k = 0; k < 65536; k++) begin
            in_index = 4'(k);
            in_data  = 32'(k);
            step();
        end
        in_valid = 1'b0;
        check_eq("wrap_ffff", 32'(writes_issued), 32'h0000FFFF);
        step();
        check_eq("wrap_last_data", update_register, 32'h0000FFFF);
        check_eq("wrap_zero", 32'(writes_issued), 32'h0);
        step();
        check_eq("wrap_idle_ue", 32'(update_enable), 32'd0);
        check_eq("wrap_hold", 32'(writes_issued), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
